// File: rtl/random_second_led.sv
// random_second_led
//   Push-button triggered LED timer. A raw button is synchronised and
//   debounced; each debounced press lights the external LED for a
//   pseudo-random whole number of seconds (1..MAX_SECONDS), with the
//   duration drawn from a free-running 16-bit LFSR.
//
// Ports
//   clk          system clock (CLK_HZ cycles per second)
//   rst_n        asynchronous active-low reset
//   btn_raw      raw, bouncy, asynchronous push-button, active-high
//   led_onboard  onboard LED, active-low, always ~led_ext
//   led_ext      external LED, active-high, 1 while a timed interval runs
//
// Build option
//   RANDOM_SECOND_RETRIGGER_EN  when defined, a press during an interval
//                               restarts it with a fresh random duration.
//                               When undefined, such presses are ignored.

module random_second_led #(
  parameter int unsigned CLK_HZ          = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned MAX_SECONDS     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic led_onboard,
  output logic led_ext
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DUR_W = $clog2(MAX_SECONDS);
  localparam int unsigned REM_W = DUR_W + 1;

  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(CLK_HZ - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (MAX_SECONDS < 2 || MAX_SECONDS > 256 ||
      (MAX_SECONDS & (MAX_SECONDS - 1)) != 0) begin : g_bad_max_seconds
    $error("MAX_SECONDS must be a power of two in 2..256");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ON   = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
  // synchronised samples that disagree with it.
  // ---------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q,  db_cnt_d;
  logic            db_lvl_q,  db_lvl_d;
  logic            db_prev_q;
  logic            press_q;

  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync2_q != db_lvl_q) begin
      // The sample that would bring the count to DEBOUNCE_CYCLES commits
      // the new level instead of being counted.
      if (db_cnt_q == DB_LAST) begin
        db_lvl_d = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      db_lvl_q  <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      db_lvl_q  <= db_lvl_d;
      db_prev_q <= db_lvl_q;
      // One-cycle pulse on the debounced rising edge; releases ignored.
      press_q   <= db_lvl_q & ~db_prev_q;
    end
  end

  // ---------------------------------------------------------------------
  // LFSR: x^16+x^14+x^13+x^11+1, Fibonacci, shifting left, free running.
  // ---------------------------------------------------------------------
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  logic [REM_W-1:0] duration;

  always_comb begin
    duration = REM_W'(lfsr_q[DUR_W-1:0]) + REM_W'(1);
  end

  // ---------------------------------------------------------------------
  // Interval FSM
  // ---------------------------------------------------------------------
  state_t           state_q,   state_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [REM_W-1:0] secs_q,    secs_d;
  logic             led_ext_q;
  logic             led_onb_q;

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    secs_d    = secs_q;
    unique case (state_q)
      S_IDLE: begin
        if (press_q) begin
          secs_d    = duration;
          sec_cnt_d = '0;
          state_d   = S_ON;
        end
      end
      S_ON: begin
`ifdef RANDOM_SECOND_RETRIGGER_EN
        // A fresh press wins over a coincident end-of-second so the
        // interval is reloaded rather than terminated.
        if (press_q) begin
          secs_d    = duration;
          sec_cnt_d = '0;
        end else begin
`else
        begin
`endif
          if (sec_cnt_q == SEC_LAST) begin
            sec_cnt_d = '0;
            secs_d    = secs_q - REM_W'(1);
            if (secs_q == REM_W'(1)) begin
              state_d = S_IDLE;
            end
          end else begin
            sec_cnt_d = sec_cnt_q + SEC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sec_cnt_q <= '0;
      secs_q    <= '0;
      led_ext_q <= 1'b0;
      led_onb_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
      secs_q    <= secs_d;
      // LEDs are loaded from the next state so they are true flop outputs
      // that track the state register without an extra cycle of delay.
      led_ext_q <= (state_d == S_ON);
      led_onb_q <= (state_d != S_ON);
    end
  end

  assign led_ext     = led_ext_q;
  assign led_onboard = led_onb_q;

endmodule

// File: tb/tb_random_second_led.sv
module tb_random_second_led;

  localparam int unsigned CLK_HZ          = 100;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned MAX_SECONDS     = 8;
  localparam int unsigned HW              = DEBOUNCE_CYCLES + 2;

  logic clk;
  logic rst_n;
  logic btn_raw;
  logic led_onboard;
  logic led_ext;

  random_second_led #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MAX_SECONDS    (MAX_SECONDS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .led_onboard(led_onboard),
    .led_ext    (led_ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model.
  //   hist[k]  = btn_raw sampled k edges ago (hist[0] = this edge)
  //   The synchronised value seen by the debouncer at an edge is the
  //   sample from two edges earlier; the debounced level flips when the
  //   last DEBOUNCE_CYCLES such values all disagree with it.
  //   A rise reaches the timer two edges later; the interval then lasts
  //   duration*CLK_HZ edges, with duration from the LFSR value of that edge.
  // ---------------------------------------------------------------------
  typedef struct packed {
    bit [HW-1:0] hist;
    bit          level;
    bit [1:0]    pipe;
    bit [15:0]   lfsr;
    bit          on;
    int unsigned rem;
    int unsigned last_dur;
  } model_t;

  model_t m;

  function automatic bit [15:0] lfsr_step(input bit [15:0] q);
    bit nb;
    nb = q[15] ^ q[13] ^ q[12] ^ q[10];
    return {q[14:0], nb};
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.lfsr = 16'hACE1;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input bit b);
    model_t      n;
    bit          all_diff;
    bit          rose;
    bit          act;
    int unsigned dur;
    n = c;
    n.hist = {c.hist[HW-2:0], b};
    all_diff = 1'b1;
    for (int k = 2; k <= int'(DEBOUNCE_CYCLES) + 1; k++) begin
      if (n.hist[k] == c.level) all_diff = 1'b0;
    end
    rose = 1'b0;
    if (all_diff) begin
      n.level = ~c.level;
      rose    = n.level;
    end
    act    = c.pipe[1];
    n.pipe = {c.pipe[0], rose};
    dur    = (int'(c.lfsr) % MAX_SECONDS) + 1;
    n.lfsr = lfsr_step(c.lfsr);
    if (c.on) begin
`ifdef RANDOM_SECOND_RETRIGGER_EN
      if (act) begin
        n.rem      = dur * CLK_HZ;
        n.last_dur = dur;
      end else begin
`else
      begin
`endif
        n.rem = c.rem - 1;
        if (n.rem == 0) n.on = 1'b0;
      end
    end else if (act) begin
      n.on       = 1'b1;
      n.rem      = dur * CLK_HZ;
      n.last_dur = dur;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, btn_raw);
  end

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  task automatic cycle();
    @(negedge clk);
    check("led_ext", 32'(led_ext), 32'(m.on));
    check("led_onboard", 32'(led_onboard), 32'(!m.on));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Press for `hold` cycles, optionally press again at `second_at` for 10
  // cycles, and measure rise latency and high time of the resulting pulse.
  task automatic run_press(input int hold, input int second_at,
                           output int lat, output int hi, output int dur_first,
                           output bit done);
    int  n;
    bit  started;
    n = 0; lat = -1; hi = 0; dur_first = 0; started = 0; done = 0;
    btn_raw = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      n++;
      if (n == hold) btn_raw = 1'b0;
      if (second_at > 0 && n == second_at) btn_raw = 1'b1;
      if (second_at > 0 && n == second_at + 10) btn_raw = 1'b0;
      if (led_ext) begin
        if (!started) begin
          started   = 1;
          lat       = n - 1;
          dur_first = int'(m.last_dur);
        end
        hi++;
      end else if (started) begin
        done = 1;
        break;
      end
    end
    btn_raw = 1'b0;
  endtask

  int lat, hi, dur1;
  bit done, seen;

  initial begin
    rst_n   = 1'b0;
    btn_raw = 1'b0;

    // Model pinned by hand-computed LFSR steps from the seed.
    check("lfsr_pin1", 32'(lfsr_step(16'hACE1)), 32'h59C3);
    check("lfsr_pin2", 32'(lfsr_step(lfsr_step(16'hACE1))), 32'hB387);

    // Reset held with a toggling button.
    for (int i = 0; i < 5; i++) begin
      btn_raw = ~btn_raw;
      cycle();
      check("rst_led_ext", 32'(led_ext), 32'd0);
      check("rst_led_onboard", 32'(led_onboard), 32'd1);
    end
    btn_raw = 1'b0;
    check("rst_lfsr_seed", 32'(dut.lfsr_q), 32'hACE1);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cycle();
      check("lfsr", 32'(dut.lfsr_q), 32'(m.lfsr));
    end

    // Clean press.
    run_press(50, 0, lat, hi, dur1, done);
    check("clean_done", 32'(done), 32'd1);
    check("clean_latency", 32'(lat), 32'(DEBOUNCE_CYCLES + 3));
    check("clean_dur_range", 32'(dur1 >= 1 && dur1 <= int'(MAX_SECONDS)), 32'd1);
    check("clean_on_time", 32'(hi), 32'(dur1 * int'(CLK_HZ)));
    idle(10);

    // Bounce rejection: 3 high / 3 low, five times.
    seen = 0;
    for (int r = 0; r < 5; r++) begin
      btn_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin cycle(); if (led_ext) seen = 1; end
      btn_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin cycle(); if (led_ext) seen = 1; end
    end
    idle(8);
    if (led_ext) seen = 1;
    check("bounce_quiet", 32'(seen), 32'd0);
    run_press(10, 0, lat, hi, dur1, done);
    check("after_bounce_done", 32'(done), 32'd1);
    check("after_bounce_latency", 32'(lat), 32'(DEBOUNCE_CYCLES + 3));
    check("after_bounce_on_time", 32'(hi), 32'(dur1 * int'(CLK_HZ)));
    idle(10);

    // Second press inside the interval.
    run_press(50, 60, lat, hi, dur1, done);
    check("second_press_done", 32'(done), 32'd1);
`ifndef RANDOM_SECOND_RETRIGGER_EN
    check("second_press_ignored", 32'(hi), 32'(dur1 * int'(CLK_HZ)));
`endif
    idle(10);

    // Reset in the middle of an interval.
    btn_raw = 1'b1;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (i == 9) btn_raw = 1'b0;
      if (led_ext) begin done = 1; break; end
    end
    btn_raw = 1'b0;
    check("midrst_lit", 32'(done), 32'd1);
    idle(20);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async_ext", 32'(led_ext), 32'd0);
    check("midrst_async_onboard", 32'(led_onboard), 32'd1);
    idle(3);
    rst_n = 1'b1;
    cycle();
    check("midrst_lfsr_restart", 32'(dut.lfsr_q), 32'(lfsr_step(16'hACE1)));
    seen = 0;
    for (int i = 0; i < 40; i++) begin cycle(); if (led_ext) seen = 1; end
    check("midrst_quiet", 32'(seen), 32'd0);

    // Randomised bursts of bouncy presses and idle gaps.
    for (int r = 0; r < 40; r++) begin
      int segs;
      segs = int'($urandom_range(1, 6));
      for (int s = 0; s < segs; s++) begin
        btn_raw = 1'($urandom_range(0, 1));
        idle(int'($urandom_range(1, 10)));
      end
      btn_raw = 1'b0;
      idle(int'($urandom_range(0, 900)));
    end

    idle(900);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/random_second_led.md
Name: random_second_led

Overview:
- Button-triggered random-duration LED timer for a 25 MHz FPGA board.
- A raw push-button is synchronised and debounced. Each debounced press lights an external LED for a pseudo-random whole number of seconds (1..MAX_SECONDS).
- The onboard LED (active-low) mirrors the external LED.
- Sits at top level, directly between board pins and LEDs.

Parameters:
- CLK_HZ, 25000000, clock cycles per second; reduced in simulation.
- DEBOUNCE_CYCLES, 1000, consecutive stable synchronised samples needed to accept a new button level (40 us at 25 MHz). Must be ≥1.
- MAX_SECONDS, 8, maximum on-time in seconds. Must be a power of two, 2..256.

Ports:
- clk  input  1  system clock, 25 MHz.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  1  raw, bouncy, asynchronous push-button, active-high.
- led_onboard  output  1  onboard LED, active-low; equals ~led_ext.
- led_ext  output  1  external LED, active-high; 1 while a timed interval runs.

Behaviour:
- Reset (rst_n=0, asynchronous): all state clears.
  - Synchroniser FFs = 0, debounced level = 0, debounce counter = 0.
  - LFSR = 16'hACE1.
  - Second counter = 0, seconds-remaining = 0, state = IDLE.
  - led_ext = 0, led_onboard = 1.
- Synchroniser: 2-flop chain on btn_raw. Only the second flop output is used downstream.
- Debounce:
  - Counter increments while the synchronised level differs from the debounced level; clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Press detect: a one-cycle pulse on the debounced 0→1 transition. Releases (1→0) are ignored.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left.
  - New bit = q[15]^q[13]^q[12]^q[10], inserted at bit 0.
  - Advances every clock cycle regardless of state; never reaches zero.
- Duration: sampled on the press pulse as (lfsr[log2(MAX_SECONDS)-1:0]) + 1, giving 1..MAX_SECONDS.
- FSM, two states:
  - IDLE: led_ext=0. On a press pulse:
    - seconds-remaining = duration;
    - second counter = 0;
    - go to ON.
  - ON: led_ext=1.
    - The second counter counts 0..CLK_HZ-1. At CLK_HZ-1 it wraps to 0 and seconds-remaining decrements.
    - When a decrement takes seconds-remaining from 1 to 0, go to IDLE.
    - Total ON time is exactly duration × CLK_HZ cycles.
- Presses during ON are ignored (base build).
- Latency: the first clk edge at which btn_raw is sampled high starts the count. After a clean rising edge, led_ext rises exactly DEBOUNCE_CYCLES+3 cycles later.
- Reset mid-interval: LED off immediately (asynchronous). The interval is discarded, and the LFSR restarts at the seed.
- Outputs are registered; no combinational path from btn_raw.

Optional Feature:
- Macro: RANDOM_SECOND_RETRIGGER_EN.
- Defined: a press pulse while in ON reloads seconds-remaining with a fresh duration from the current LFSR value and clears the second counter. led_ext stays 1 with no glitch.
- Undefined: presses while in ON have no effect.

Test Plan (CLK_HZ=100, DEBOUNCE_CYCLES=4, MAX_SECONDS=8 unless noted):
- Reset check: hold rst_n=0 for 5 cycles, btn_raw toggling → led_ext=0, led_onboard=1 throughout. After release, LFSR steps from 16'hACE1 per the polynomial (check against a bench model for 20 cycles).
- Clean press: btn_raw=1 for 50 cycles → led_ext rises exactly 7 cycles after first sampled high. Stays high exactly (model lfsr[2:0]+1)×100 cycles, then 0; led_onboard always the inverse.
- Bounce rejection: btn_raw pulses 1 for 3 cycles, 0 for 3 cycles, repeated 5 times → led_ext stays 0. A following 10-cycle stable high press lights the LED.
- Press during ON (base build): second press mid-interval → led_ext falls at the time set by the first duration only. With RETRIGGER_EN, the falling time = press2 time + (new duration×100) + pipeline latency.
- Reset mid-interval: assert rst_n=0 while led_ext=1 → led_ext drops in the same timestep without waiting for clk. After release, no LED activity until a new press.
- Default parameters (25 MHz): press 100 us at t=1 ms and again at t=21.1 ms → led_ext=1 from ~1.04 ms onward. The second press is ignored; the LED is still on at t=71 ms.
